// File: rtl/fc_classifier.sv
// Fully-connected classifier stage that follows CONV2.
// A start pulse makes it read the flattened feature map, the weights and the biases
// from the shared BRAM. It computes NOut signed fixed-point logits, writes them back
// to BRAM and reports the argmax class.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   fc_start_i     one-cycle start pulse, honoured only in idle
//   mem_out_i      BRAM read data, valid one cycle after the address
//   memaddr_o      BRAM address; wea_w_o/mem_in_o form the BRAM write port
//   fc_busy_o      high while the block owns the BRAM port
//   fc_finish_o    one-cycle completion pulse
//   class_idx_o    argmax index, held until the next run completes
//   class_score_o  logit of class_idx_o
module fc_classifier #(
  parameter int unsigned Width      = 8,
  parameter int unsigned Decimal    = 4,
  parameter int unsigned MemAddrBit = 17,
  parameter int unsigned NIn        = 256,
  parameter int unsigned NOut       = 10,
  parameter int unsigned InAddr     = 4549,
  parameter int unsigned WAddr      = 4805,
  parameter int unsigned BAddr      = 7365,
  parameter int unsigned OutAddr    = 7375
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fc_start_i,
  input  logic [Width-1:0]      mem_out_i,
  output logic [MemAddrBit-1:0] memaddr_o,
  output logic                  wea_w_o,
  output logic [Width-1:0]      mem_in_o,
  output logic                  fc_busy_o,
  output logic                  fc_finish_o,
  output logic [3:0]            class_idx_o,
  output logic [Width-1:0]      class_score_o
);

  localparam int unsigned IW   = $clog2(NIn);
  localparam int unsigned AccW = 2 * Width + IW;

  localparam logic signed [AccW:0]  SatMax   = (AccW + 1)'(2 ** (Width - 1) - 1);
  localparam logic signed [AccW:0]  SatMin   = ~SatMax;
  localparam logic [Width-1:0]      MinScore = {1'b1, {(Width - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StRdX, StRdW, StRdB, StAccB, StWr, StDone} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d;
  logic [3:0]          j_q, j_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [Width-1:0]    x_q, x_d;
  logic [Width-1:0]    res_q, res_d;
  logic [Width-1:0]    best_score_q, best_score_d;
  logic [3:0]          best_idx_q, best_idx_d;
  logic [3:0]          class_idx_q, class_idx_d;
  logic [Width-1:0]    class_score_q, class_score_d;

  logic signed [2*Width-1:0] prod;
  logic [AccW-1:0]           prod_ext;
  logic signed [AccW:0]      bias_sh;
  logic signed [AccW:0]      sum;
  logic signed [AccW:0]      shifted;
  logic [Width-1:0]          res_sat;

  assign prod     = $signed(x_q) * $signed(mem_out_i);
  assign prod_ext = {{IW{prod[2*Width-1]}}, prod};

  // Bias is aligned to the product scale (2*Decimal fractional bits) before the sum.
  assign bias_sh = $signed({{(AccW + 1 - Width){mem_out_i[Width-1]}}, mem_out_i}) <<< Decimal;
  assign sum     = $signed({acc_q[AccW-1], acc_q}) + bias_sh;
  assign shifted = sum >>> Decimal;  // arithmetic shift floors toward minus infinity

  always_comb begin
    if (shifted > SatMax)      res_sat = SatMax[Width-1:0];
    else if (shifted < SatMin) res_sat = SatMin[Width-1:0];
    else                       res_sat = shifted[Width-1:0];
  end

  assign mem_in_o      = res_q;
  assign class_idx_o   = class_idx_q;
  assign class_score_o = class_score_q;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    acc_d         = acc_q;
    x_d           = x_q;
    res_d         = res_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    memaddr_o     = '0;
    wea_w_o       = 1'b0;
    fc_busy_o     = 1'b1;
    fc_finish_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        fc_busy_o = 1'b0;
        if (fc_start_i) begin
          state_d      = StRdX;
          i_d          = '0;
          j_d          = '0;
          acc_d        = '0;
          best_score_d = MinScore;
          best_idx_d   = '0;
        end
      end
      StRdX: begin
        memaddr_o = MemAddrBit'(InAddr) + MemAddrBit'(i_q);
        // Read data here is the weight of input i-1; nothing is pending at i == 0.
        if (i_q != '0) acc_d = acc_q + prod_ext;
        state_d = StRdW;
      end
      StRdW: begin
        memaddr_o = MemAddrBit'(WAddr) + MemAddrBit'(j_q) * MemAddrBit'(NIn) + MemAddrBit'(i_q);
        x_d       = mem_out_i;
        if (i_q == IW'(NIn - 1)) begin
          state_d = StRdB;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = StRdX;
        end
      end
      StRdB: begin
        memaddr_o = MemAddrBit'(BAddr) + MemAddrBit'(j_q);
        acc_d     = acc_q + prod_ext;
        state_d   = StAccB;
      end
      StAccB: begin
        res_d   = res_sat;
        state_d = StWr;
      end
      StWr: begin
        memaddr_o = MemAddrBit'(OutAddr) + MemAddrBit'(j_q);
        wea_w_o   = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if ($signed(res_q) > $signed(best_score_q)) begin
          best_score_d = res_q;
          best_idx_d   = j_q;
        end
        acc_d = '0;
        i_d   = '0;
        if (j_q == 4'(NOut - 1)) begin
          state_d = StDone;
        end else begin
          j_d     = j_q + 4'd1;
          state_d = StRdX;
        end
      end
      StDone: begin
        fc_busy_o     = 1'b0;
        fc_finish_o   = 1'b1;
        class_idx_d   = best_idx_q;
        class_score_d = best_score_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      i_q           <= '0;
      j_q           <= '0;
      acc_q         <= '0;
      x_q           <= '0;
      res_q         <= '0;
      best_score_q  <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      acc_q         <= acc_d;
      x_q           <= x_d;
      res_q         <= res_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
module tb_fc_classifier;

  localparam int InA = 4549;
  localparam int WA  = 4805;
  localparam int BA  = 7365;
  localparam int OA  = 7375;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fc_start = 1'b0;
  logic [7:0]  mem_out = 8'h00;
  logic [16:0] memaddr;
  logic        wea_w;
  logic [7:0]  mem_in;
  logic        fc_busy;
  logic        fc_finish;
  logic [3:0]  class_idx;
  logic [7:0]  class_score;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8192];
  int         wlog[$];

  logic [7:0] exp_logit [10];
  int         exp_idx;
  logic [7:0] exp_score;

  always #5 clk = ~clk;

  fc_classifier dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fc_start_i   (fc_start),
    .mem_out_i    (mem_out),
    .memaddr_o    (memaddr),
    .wea_w_o      (wea_w),
    .mem_in_o     (mem_in),
    .fc_busy_o    (fc_busy),
    .fc_finish_o  (fc_finish),
    .class_idx_o  (class_idx),
    .class_score_o(class_score)
  );

  // Synchronous-read BRAM model with a log of every write address.
  always @(posedge clk) begin
    if (memaddr < 17'd8192) begin
      if (wea_w) mem[memaddr[12:0]] <= mem_in;
      mem_out <= mem[memaddr[12:0]];
    end
    if (wea_w) wlog.push_back(int'(memaddr));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: integer dot product, bias scaled by 16, floor shift, clamp, first-max argmax.
  task automatic model();
    int best;
    best    = -1000;
    exp_idx = 0;
    for (int j = 0; j < 10; j++) begin
      int s;
      int r;
      s = 0;
      for (int i = 0; i < 256; i++) s += $signed(mem[InA + i]) * $signed(mem[WA + j * 256 + i]);
      s += $signed(mem[BA + j]) * 16;
      r = s >>> 4;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      exp_logit[j] = 8'(r);
      if (r > best) begin
        best    = r;
        exp_idx = j;
      end
    end
    exp_score = 8'(best);
  endtask

  task automatic clear_mem();
    for (int a = InA; a < OA + 10; a++) mem[a] = 8'h00;
  endtask

  task automatic run_fc(input string tag, input bit inject);
    int n;
    model();
    wlog.delete();
    @(negedge clk);
    fc_start = 1'b1;
    @(negedge clk);
    fc_start = 1'b0;
    n = 1;
    check({tag, " busy"}, 32'(fc_busy), 32'd1);
    while (!fc_finish && n < 6000) begin
      @(negedge clk);
      n++;
      fc_start = (inject && n == 100);
    end
    fc_start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd5151);
    check({tag, " busy_done"}, 32'(fc_busy), 32'd0);
    @(negedge clk);
    check({tag, " finish_pulse"}, 32'(fc_finish), 32'd0);
    check({tag, " class_idx"}, 32'(class_idx), 32'(exp_idx));
    check({tag, " class_score"}, 32'(class_score), 32'(exp_score));
    check({tag, " nwrites"}, 32'(wlog.size()), 32'd10);
    for (int j = 0; j < 10; j++) begin
      if (j < wlog.size()) check({tag, " waddr"}, 32'(wlog[j]), 32'(OA + j));
      check({tag, " logit"}, 32'(mem[OA + j]), 32'(exp_logit[j]));
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;

    // Reset state
    #12;
    check("rst memaddr", 32'(memaddr), 32'd0);
    check("rst wea", 32'(wea_w), 32'd0);
    check("rst busy", 32'(fc_busy), 32'd0);
    check("rst finish", 32'(fc_finish), 32'd0);
    check("rst idx", 32'(class_idx), 32'd0);
    check("rst score", 32'(class_score), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: positive saturation on neuron 3
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[InA + i] = 8'h10;
      mem[WA + 3 * 256 + i] = 8'h10;
    end
    run_fc("t1", 1'b0);
    check("t1 spec idx", 32'(class_idx), 32'd3);
    check("t1 spec score", 32'(class_score), 32'h7f);

    // 2: identical logits, tie keeps index 0
    clear_mem();
    mem[InA] = 8'h18;
    for (int j = 0; j < 10; j++) begin
      mem[WA + j * 256] = 8'h20;
      mem[BA + j] = 8'h08;
    end
    run_fc("t2", 1'b0);
    check("t2 spec idx", 32'(class_idx), 32'd0);
    check("t2 spec logit9", 32'(mem[OA + 9]), 32'h38);

    // 3a: negative saturation
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[InA + i] = 8'h10;
      mem[WA + i] = 8'hf0;
    end
    run_fc("t3a", 1'b0);
    check("t3a spec logit0", 32'(mem[OA]), 32'h80);

    // 3b: 0.5 floors to 0
    clear_mem();
    mem[InA] = 8'h01;
    mem[WA + 256] = 8'h08;
    run_fc("t3b", 1'b0);
    check("t3b spec logit1", 32'(mem[OA + 1]), 32'h00);

    // 4: bias only, first of two equal maxima wins; also ignored second start
    clear_mem();
    for (int j = 0; j < 10; j++) mem[BA + j] = 8'hfb;
    mem[BA + 2] = 8'h05;
    mem[BA + 7] = 8'h05;
    run_fc("t4", 1'b1);
    check("t4 spec idx", 32'(class_idx), 32'd2);
    check("t4 spec score", 32'(class_score), 32'h05);
    check("t4 spec m7382", 32'(mem[7382]), 32'h05);

    // Random full-range and small-range runs
    for (int a = InA; a < OA; a++) mem[a] = 8'($urandom);
    run_fc("rand_full", 1'b0);
    for (int a = InA; a < OA; a++) mem[a] = 8'($urandom_range(0, 15)) - 8'd8;
    run_fc("rand_small", 1'b0);

    // 6: reset mid-run, then a clean rerun
    for (int a = InA; a < OA; a++) mem[a] = 8'($urandom_range(0, 7)) - 8'd3;
    wlog.delete();
    @(negedge clk);
    fc_start = 1'b1;
    @(negedge clk);
    fc_start = 1'b0;
    repeat (1999) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst memaddr", 32'(memaddr), 32'd0);
    check("mid_rst wea", 32'(wea_w), 32'd0);
    check("mid_rst mem_in", 32'(mem_in), 32'd0);
    check("mid_rst busy", 32'(fc_busy), 32'd0);
    check("mid_rst idx", 32'(class_idx), 32'd0);
    check("mid_rst score", 32'(class_score), 32'd0);
    check("mid_rst writes", 32'(wlog.size()), 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst writes", 32'(wlog.size()), 32'd3);
    check("post_rst busy", 32'(fc_busy), 32'd0);
    run_fc("rerun", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
